// File: rtl/cc_pkg.sv
// Shared widths, line-entry type and serializer state encoding for the cache
// controller's line datapaths.
package cc_pkg;

  localparam int CC_LINE_W = 512;
  localparam int CC_BEAT_W = 64;
  localparam int CC_BEATS  = 8;
  localparam int CC_OFS_W  = 3;

  typedef logic [CC_LINE_W-1:0] cc_line_t;

  typedef struct packed {
    logic                valid;
    cc_line_t            data;
    logic [CC_OFS_W-1:0] offset;
  } cc_line_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BURST = 2'd1,
    FULL  = 2'd2
  } cc_ser_state_e;

  // Wrap-order beat index: the 3-bit add wraps naturally mod 8.
  function automatic logic [CC_OFS_W-1:0] cc_beat_idx(input logic [CC_OFS_W-1:0] ofs,
                                                      input logic [CC_OFS_W-1:0] cnt);
    return ofs + cnt;
  endfunction

endpackage

// File: rtl/cc_beat_select.sv
// Combinational 8:1 word mux selecting one 64-bit word of a cache line.
// Shared by the read serializer and the write-back path.
module cc_beat_select
  import cc_pkg::*;
(
  input  logic [CC_LINE_W-1:0] line,
  input  logic [CC_OFS_W-1:0]  idx,
  output logic [CC_BEAT_W-1:0] word
);

  // Word idx lives at bits [64*idx+63 : 64*idx].
  always_comb begin
    word = line[idx*CC_BEAT_W +: CC_BEAT_W];
  end

endmodule

// File: rtl/cc_line_serializer.sv
// Streams a 512-bit cache line as an 8-beat wrap-order burst, critical word
// first, with an active + pending entry so consecutive lines have no bubble.
module cc_line_serializer
  import cc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_valid_i,
  output logic                 line_ready_o,
  input  logic [CC_LINE_W-1:0] line_data_i,
  input  logic [CC_OFS_W-1:0]  line_offset_i,
  output logic [CC_BEAT_W-1:0] inct_rdata_o,
  output logic                 inct_rlast_o,
  output logic                 inct_rvalid_o,
  input  logic                 inct_rready_i,
  output logic                 busy_o
);

  cc_ser_state_e       state_r, state_n;
  cc_line_entry_t      act_r, act_n;
  cc_line_entry_t      pend_r, pend_n;
  logic [CC_OFS_W-1:0] cnt_r, cnt_n;

  logic                accept_s;
  logic                xfer_s;
  logic                last_s;
  logic                retire_s;
  logic [CC_OFS_W-1:0] beat_idx_s;
  logic [CC_BEAT_W-1:0] word_s;
  cc_line_entry_t      new_entry_s;

  assign last_s      = (cnt_r == CC_OFS_W'(CC_BEATS - 1));
  assign accept_s    = line_valid_i & ~pend_r.valid;
  assign xfer_s      = act_r.valid & inct_rready_i;
  assign retire_s    = xfer_s & last_s;
  assign beat_idx_s  = cc_beat_idx(act_r.offset, cnt_r);
  assign new_entry_s = '{valid: 1'b1, data: line_data_i, offset: line_offset_i};

  cc_beat_select u_beat_select (
    .line (act_r.data),
    .idx  (beat_idx_s),
    .word (word_s)
  );

  // Outputs depend on registered state only, so they hold while stalled.
  assign line_ready_o  = ~pend_r.valid;
  assign inct_rvalid_o = act_r.valid;
  assign inct_rlast_o  = act_r.valid & last_s;
  assign inct_rdata_o  = act_r.valid ? word_s : {CC_BEAT_W{1'b0}};
  assign busy_o        = act_r.valid | pend_r.valid;

  // State, entry and beat-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      act_r   <= '0;
      pend_r  <= '0;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_n;
      act_r   <= act_n;
      pend_r  <= pend_n;
      cnt_r   <= cnt_n;
    end
  end

  // Occupancy FSM: follows accept/retire events.
  always_comb begin
    state_n = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_n = BURST;
        else          state_n = EMPTY;
      end
      BURST: begin
        if (accept_s && !retire_s)      state_n = FULL;
        else if (retire_s && !accept_s) state_n = EMPTY;
        else                            state_n = BURST;
      end
      FULL: begin
        if (retire_s) state_n = BURST;
        else          state_n = FULL;
      end
      default: state_n = EMPTY;
    endcase
  end

  // Entry and counter update; a retiring line is replaced on the same edge.
  always_comb begin
    act_n  = act_r;
    pend_n = pend_r;
    cnt_n  = cnt_r;
    if (xfer_s) begin
      cnt_n = cnt_r + 3'd1;
    end else begin
      cnt_n = cnt_r;
    end
    if (retire_s) begin
      if (pend_r.valid) begin
        act_n        = pend_r;
        pend_n.valid = 1'b0;
      end else if (accept_s) begin
        act_n = new_entry_s;
      end else begin
        act_n.valid = 1'b0;
      end
    end else if (accept_s) begin
      if (!act_r.valid) begin
        act_n = new_entry_s;
      end else begin
        pend_n = new_entry_s;
      end
    end else begin
      act_n = act_r;
    end
  end

endmodule

// File: tb/tb_cc_line_serializer.sv
// Scoreboard bench: accepted lines are expanded into expected wrap-order beats,
// and a monitor pops and compares them on every R handshake.
module tb_cc_line_serializer;
  import cc_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           line_valid;
  logic           line_ready;
  logic [511:0]   line_data;
  logic [2:0]     line_offset;
  logic [63:0]    rdata;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic           busy;

  cc_line_serializer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_valid_i  (line_valid),
    .line_ready_o  (line_ready),
    .line_data_i   (line_data),
    .line_offset_i (line_offset),
    .inct_rdata_o  (rdata),
    .inct_rlast_o  (rlast),
    .inct_rvalid_o (rvalid),
    .inct_rready_i (rready),
    .busy_o        (busy)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          held;
  int          beats_seen;
  int          n_checks;
  int          n_pass;
  bit          rst_seen;
  bit          stall_prev;
  logic [63:0] prev_d;
  logic        prev_l;
  int          rr_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor and reference model: lines held = accepted minus retired.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held       = 0;
      rst_seen   = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (rst_seen) begin
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(line_ready), 64'd1);
        rst_seen = 1'b0;
      end
      chk("line_ready", 64'(line_ready), 64'(held < 2));
      chk("rvalid", 64'(rvalid), 64'(held > 0));
      chk("busy", 64'(busy), 64'(held > 0));
      if (!rvalid) chk("idle_rdata", {rdata[63:1], rlast}, 64'd0);
      if (stall_prev) begin
        chk("stall_rdata", rdata, prev_d);
        chk("stall_rlast", 64'(rlast), 64'(prev_l));
        chk("stall_rvalid", 64'(rvalid), 64'd1);
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", rdata, e.d);
          chk("beat_last", 64'(rlast), 64'(e.l));
          if (e.l) held--;
        end
        beats_seen++;
      end
      if (line_valid && line_ready) begin
        for (int k = 0; k < 8; k++) begin
          beat_t b;
          int idx;
          idx = (int'(line_offset) + k) % 8;
          b.d = line_data[idx*64 +: 64];
          b.l = (k == 7);
          exp_q.push_back(b);
        end
        held++;
      end
      stall_prev = rvalid && !rready;
      prev_d     = rdata;
      prev_l     = rlast;
    end
  end

  // rready generator: 0 = always, 1 = random, 2 = never, 3 = 1,0,0 pattern.
  initial begin
    int ph;
    ph = 0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = 1'($urandom_range(0, 1));
        2: rready = 1'b0;
        3: begin rready = (ph == 0); ph = (ph + 1) % 3; end
        default: rready = 1'b1;
      endcase
    end
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [511:0] pattern_line();
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(w + 1);
    return l;
  endfunction

  task automatic send(input logic [511:0] d, input logic [2:0] ofs);
    bit acc;
    acc = 1'b0;
    line_valid  = 1'b1;
    line_data   = d;
    line_offset = ofs;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = line_ready;
      @(posedge clk);
      #1;
    end
    line_valid  = 1'b0;
    line_data   = rand_line();
    line_offset = 3'($urandom_range(0, 7));
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(posedge clk);
      done = (held == 0) && (exp_q.size() == 0);
    end
    #1;
    chk("drain", 64'(done), 64'd1);
  endtask

  initial begin
    held = 0; beats_seen = 0; n_checks = 0; n_pass = 0;
    rst_seen = 1'b0; stall_prev = 1'b0; rr_mode = 0;
    rst_n = 1'b0; line_valid = 1'b0; line_data = '0; line_offset = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(pattern_line(), 3'd0);
    drain();
    send(pattern_line(), 3'd5);
    drain();

    rr_mode = 3;
    send(rand_line(), 3'd3);
    drain();

    rr_mode = 0;
    send(rand_line(), 3'd2);
    send(rand_line(), 3'd7);
    drain();

    rr_mode = 2;
    send(rand_line(), 3'd1);
    send(rand_line(), 3'd6);
    fork
      send(rand_line(), 3'd4);
      begin
        repeat (12) @(posedge clk);
        #1 rr_mode = 0;
      end
    join
    drain();

    begin
      int base;
      bit hit;
      base = beats_seen;
      hit  = 1'b0;
      send(rand_line(), 3'd6);
      for (int t = 0; t < 50 && !hit; t++) begin
        @(posedge clk);
        hit = (beats_seen >= base + 3);
      end
      chk("beat3_reached", 64'(hit), 64'd1);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
    end
    send(rand_line(), 3'd3);
    drain();

    rr_mode = 1;
    for (int n = 0; n < 20; n++) begin
      send(rand_line(), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cc_line_serializer.md
# cc_line_serializer

Transmit-side counterpart of the cache controller's fill path: accepts one 512-bit cache line plus its critical-word offset and streams it to the CPU-side interconnect as an 8-beat, 64-bit AXI-style R burst in wrap order, critical word first. Sits between the hit/fill data mux and the INCT R channel. A two-entry line buffer (active + pending) sustains back-to-back bursts with no idle cycle between lines.

## Interface
Parameters:
- none; all widths fixed by cc_pkg constants.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- line_valid_i  in  1  a line is offered
- line_ready_o  out  1  serializer can take a line this cycle
- line_data_i  in  512  line data; word w occupies bits [64w+63:64w]
- line_offset_i  in  3  critical word index (request addr[5:3])
- inct_rdata_o  out  64  beat data
- inct_rlast_o  out  1  last beat of burst
- inct_rvalid_o  out  1  beat valid
- inct_rready_i  in  1  downstream accepts beat
- busy_o  out  1  active or pending entry occupied

## Operation
- Storage: active entry {valid, data[511:0], offset[2:0]}, pending entry (same fields), beat counter cnt[2:0].
- Line accept: line_valid_i & line_ready_o. line_ready_o = !pending_valid (combinational from registers only; no dependence on line_valid_i or inct_rready_i).
- Beat index = (active_offset + cnt) mod 8, 3-bit wraparound add; inct_rdata_o = word[beat index] of active data.
- inct_rvalid_o = active_valid; inct_rlast_o = active_valid & (cnt == 7).
- Beat transfer: inct_rvalid_o & inct_rready_i; cnt increments; at cnt == 7, cnt returns to 0 and the active entry retires.
- Retire/refill on the same edge: if pending_valid, pending moves to active (pending cleared); else, if a line is accepted that cycle, it loads directly into active; else active_valid clears.
- Accept while active is not retiring: loads into active if active empty, otherwise into pending.
- Ordering strictly FIFO; a line is never split or reordered.
- inct_rdata_o is 0 whenever inct_rvalid_o is 0.
- busy_o = active_valid | pending_valid.
- States: EMPTY (no active), BURST (active only), FULL (active + pending). Transitions:
  - EMPTY -> BURST on accept.
  - BURST -> FULL on accept without retire.
  - BURST -> EMPTY on retire without accept.
  - BURST stays BURST on accept with retire.
  - FULL -> BURST on retire.

## Timing
- Reset values: inct_rvalid_o 0, inct_rlast_o 0, inct_rdata_o 0, line_ready_o 1, busy_o 0, cnt 0, both entries invalid.
- Latency: line accepted at edge N into an empty serializer -> first beat valid in the cycle after N; the burst takes 8 cycles under continuous rready.
- Back-to-back: the first beat of the next line is valid in the cycle immediately after the last-beat handshake; zero bubbles.
- AXI stability: while inct_rvalid_o & !inct_rready_i, rdata, rlast and rvalid hold unchanged. Backpressure stalls cnt indefinitely.
- Reset mid-burst: all state discarded at the next edge, with no partial-burst completion; outputs return to reset values.
- line_data_i and line_offset_i are sampled only at the accept edge.

## Structure
- cc_pkg holds:
  - CC_LINE_W = 512, CC_BEAT_W = 64, CC_BEATS = 8, CC_OFS_W = 3
  - typedef cc_line_t (packed 512)
  - typedef cc_line_entry_t {valid, data, offset}
  - enum cc_ser_state_e {EMPTY, BURST, FULL} for the bench and assertions; RTL may derive state from the valid bits.
- One sub-module, cc_beat_select: combinational 8:1 64-bit word mux indexed by the wrapped beat index. Reused by the write-back path.

## Test plan
- Single line, data word w = 64'h1111_1111_1111_1111 * (w+1), offset 0, rready held 1 -> beats 1..8 in order on consecutive cycles, rlast only on beat 8, line_ready_o stays 1.
- Same line, offset 5 -> word order 5,6,7,0,1,2,3,4; rlast on word 4; rdata 0 after the burst.
- Backpressure: rready toggles 1,0,0,1,... during a burst -> no beat lost or duplicated, rdata and rlast stable through each stall, 8 handshakes total.
- Back-to-back: lines A (offset 2) and B (offset 7) offered on consecutive cycles with rready 1 -> 16 contiguous valid beats; B begins with word 7 the cycle after A's rlast; line_ready_o drops for exactly the cycles in which both entries are full.
- Full stall: three lines offered with rready 0 -> third waits (line_ready_o 0) until A retires; output order is A, B, C.
- Reset mid-burst: rst_n low after beat 3 -> next cycle rvalid 0, busy_o 0, line_ready_o 1; a new line afterwards starts at its critical word with cnt 0.
